conv_operand_sequencer: RTL
===========================

Name: conv_operand_sequencer

Overview:
Upstream feeder for the convolution MAC stage. On start, it walks a 3x3 kernel over a 10x11 8-bit feature map held in synchronous-read RAM, producing the 8x9 valid-mode output (648 taps in total). It drives feature-map and weight read addresses, pairs the returned operands, and presents them to the MAC with enable, first-tap and last-tap strobes plus the output coordinate.

Parameters:
IMG_W, 11, feature map width
IMG_H, 10, feature map height
K, 3, kernel side length (square kernel)
DATA_W, 8, operand width
ADDR_W, 10, feature-map address width (must cover IMG_W*IMG_H-1)
WADDR_W, 4, weight address width (must cover K*K-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin one full-map pass; sampled only in IDLE
hold  in  1  stall request from downstream; freezes the entire sequencer while high
fmap_addr  out  ADDR_W  feature RAM read address
fmap_rdata  in  DATA_W  feature RAM data, valid 1 cycle after its address
w_addr  out  WADDR_W  weight ROM read address
w_rdata  in  DATA_W  weight ROM data, valid 1 cycle after its address
mac_a  out  DATA_W  registered feature operand
mac_b  out  DATA_W  registered weight operand
mac_en  out  1  operand pair valid this cycle; MAC must consume it
mac_first  out  1  first tap of an output pixel; MAC loads the product instead of accumulating
mac_last  out  1  last tap of an output pixel; accumulator is final after this cycle
out_x  out  4  output column of the current tap, 0..IMG_W-K
out_y  out  4  output row of the current tap, 0..IMG_H-K
busy  out  1  high from the cycle after start is accepted until done
done  out  1  1-cycle pulse when the final tap has been presented

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Reset mid-pass aborts immediately. No done pulse is produced, and the next pass requires a fresh start.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start=1. start is ignored in every other state.
  - RUN -> DRAIN after the cycle that issues the last tap's addresses.
  - DRAIN -> DONE once 2 pipeline stages have flushed.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
- Loop order, outermost first: oy 0..IMG_H-K, ox 0..IMG_W-K, ky 0..K-1, kx 0..K-1. One tap is issued per non-held RUN cycle.
- Address rules:
  - fmap_addr = (oy+ky)*IMG_W + (ox+kx).
  - w_addr = ky*K + kx.
  - Both are computed with incremental counters; no multipliers.
  - Addresses are registered outputs, valid from the first RUN cycle.
- Pipeline:
  - Stage 0: address registers.
  - Stage 1: RAM/ROM data returns.
  - Stage 2: mac_a/mac_b are registered from rdata, with mac_en/first/last/out_x/out_y aligned to the same cycle.
  - Latency: start sampled at cycle T; first address at T+1; first mac_en at T+3.
- Strobes:
  - mac_first=1 when ky=kx=0.
  - mac_last=1 when ky=kx=K-1.
  - Both are qualified by mac_en, and both are 0 whenever mac_en=0.
- hold:
  - When high, every counter, address and pipeline register holds its value.
  - mac_en, mac_first and mac_last are forced to 0 while hold=1, so no pair is consumed twice.
  - The held address is re-read from the synchronous RAM, giving identical data.
  - Release resumes exactly at the next tap.
  - hold during DRAIN also freezes the drain.
  - hold during DONE or IDLE has no effect.
- Counts per pass: exactly (IMG_H-K+1)*(IMG_W-K+1)*K*K mac_en cycles (648 at defaults) and 72 mac_last cycles.
- Wrap-around: kx wraps at K-1 into ky; ky wraps into ox; ox wraps at IMG_W-K into oy. The tap at oy=IMG_H-K, ox=IMG_W-K, ky=kx=K-1 is terminal. fmap_addr never exceeds IMG_W*IMG_H-1 (109 at defaults).
- busy is high in RUN and DRAIN and low in IDLE and DONE. mac_en is never high outside busy.

Test Plan:
- Reset then start pulse, no hold -> fmap_addr sequence begins 0,1,2,11,12,13,22,23,24; w_addr 0..8. First mac_en 3 cycles after start, with mac_first=1, out_x=0, out_y=0.
- Full pass with RAM data = address, weights = 1 -> each mac_last pixel at (oy,ox) sums to 9*(oy*11+ox)+108. Pixel (7,8) has first address 85, last address 109, and sum 873. Exactly 648 mac_en and 72 mac_last, then one done pulse followed by busy=0.
- hold asserted for 5 cycles mid-pixel (after tap 4 of pixel (0,1)) -> no mac_en during hold; addresses frozen; the tap sequence resumes unchanged. Totals still 648 and 72.
- start re-pulsed while busy, and again during DONE -> ignored. Exactly one done per accepted start.
- rst asserted at tap 300 -> all outputs 0 next cycle, no done. New start restarts at fmap_addr 0.
- start and hold high in the same IDLE cycle -> start accepted; RUN remains frozen until hold drops; first mac_en 3 non-held cycles later.

Source files
------------

// File: rtl/conv_operand_sequencer_if.sv
// rtl/conv_operand_sequencer_if.sv - operand sequencer bus between control, memories and MAC
// Ports (master = sequencer side):
//   start, hold               control inputs to the sequencer
//   fmap_addr / fmap_rdata    feature RAM read address and data (1-cycle read latency)
//   w_addr / w_rdata          weight ROM read address and data (1-cycle read latency)
//   mac_a, mac_b              registered operand pair for the MAC
//   mac_en, mac_first, mac_last, out_x, out_y   tap qualifiers and output coordinate
//   busy, done                pass status
interface conv_operand_sequencer_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 4
);
    logic               start;
    logic               hold;
    logic [ADDR_W-1:0]  fmap_addr;
    logic [DATA_W-1:0]  fmap_rdata;
    logic [WADDR_W-1:0] w_addr;
    logic [DATA_W-1:0]  w_rdata;
    logic [DATA_W-1:0]  mac_a;
    logic [DATA_W-1:0]  mac_b;
    logic               mac_en;
    logic               mac_first;
    logic               mac_last;
    logic [3:0]         out_x;
    logic [3:0]         out_y;
    logic               busy;
    logic               done;

    modport master (
        input  start, hold, fmap_rdata, w_rdata,
        output fmap_addr, w_addr, mac_a, mac_b, mac_en, mac_first, mac_last,
               out_x, out_y, busy, done
    );

    modport slave (
        output start, hold, fmap_rdata, w_rdata,
        input  fmap_addr, w_addr, mac_a, mac_b, mac_en, mac_first, mac_last,
               out_x, out_y, busy, done
    );
endinterface

// File: rtl/conv_operand_sequencer.sv
// rtl/conv_operand_sequencer.sv - walks a KxK kernel over the feature map and feeds operand pairs to the MAC
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   conv_operand_sequencer_if.master: start/hold in, RAM/ROM addresses out and data in,
//         MAC operands with en/first/last strobes and out_x/out_y, busy/done status
module conv_operand_sequencer #(
    parameter int IMG_W   = 11,
    parameter int IMG_H   = 10,
    parameter int K       = 3,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 4
) (
    input  logic clk,
    input  logic rst,
    conv_operand_sequencer_if.master bus
);
    localparam int OX_MAX = IMG_W - K;
    localparam int OY_MAX = IMG_H - K;
    localparam int KW     = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [3:0]         ox, oy;
    logic [KW-1:0]      kx, ky;
    logic [ADDR_W-1:0]  fmap_addr, pix_base;
    logic [WADDR_W-1:0] w_addr;
    logic               drain_cnt;

    logic               s1_valid, s1_first, s1_last;
    logic [3:0]         s1_x, s1_y;
    logic               s2_valid, s2_first, s2_last;
    logic [3:0]         s2_x, s2_y;
    logic [DATA_W-1:0]  mac_a, mac_b, skid_a, skid_b;
    logic               frozen_d;

    logic busy_state, freeze, run_go, tap_first, tap_last, tap_term;

    assign busy_state = (state == RUN) || (state == DRAIN);
    assign freeze     = busy_state && bus.hold;
    assign run_go     = (state == RUN) && !bus.hold;
    assign tap_first  = (kx == '0) && (ky == '0);
    assign tap_last   = (kx == KW'(K - 1)) && (ky == KW'(K - 1));
    assign tap_term   = tap_last && (ox == 4'(OX_MAX)) && (oy == 4'(OY_MAX));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (run_go && tap_term) state_nx = DRAIN;
            DRAIN:   if (!bus.hold && drain_cnt) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ox        <= '0;
            oy        <= '0;
            kx        <= '0;
            ky        <= '0;
            fmap_addr <= '0;
            pix_base  <= '0;
            w_addr    <= '0;
            drain_cnt <= 1'b0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_x      <= '0;
            s2_y      <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            skid_a    <= '0;
            skid_b    <= '0;
            frozen_d  <= 1'b0;
        end else begin
            state    <= state_nx;
            frozen_d <= freeze;

            // Address generation is purely incremental: step within the kernel row,
            // jump to the next kernel row, or move the pixel base on to the next pixel.
            if (run_go) begin
                if (tap_term) begin
                    ox        <= '0;
                    oy        <= '0;
                    kx        <= '0;
                    ky        <= '0;
                    fmap_addr <= '0;
                    pix_base  <= '0;
                    w_addr    <= '0;
                end else if (kx != KW'(K - 1)) begin
                    kx        <= kx + 1'b1;
                    fmap_addr <= fmap_addr + 1'b1;
                    w_addr    <= w_addr + 1'b1;
                end else if (ky != KW'(K - 1)) begin
                    kx        <= '0;
                    ky        <= ky + 1'b1;
                    fmap_addr <= fmap_addr + ADDR_W'(IMG_W - K + 1);
                    w_addr    <= w_addr + 1'b1;
                end else begin
                    kx     <= '0;
                    ky     <= '0;
                    w_addr <= '0;
                    if (ox != 4'(OX_MAX)) begin
                        ox        <= ox + 1'b1;
                        pix_base  <= pix_base + 1'b1;
                        fmap_addr <= pix_base + 1'b1;
                    end else begin
                        // Last column of a row: skipping K positions lands on the next row start.
                        ox        <= '0;
                        oy        <= oy + 1'b1;
                        pix_base  <= pix_base + ADDR_W'(K);
                        fmap_addr <= pix_base + ADDR_W'(K);
                    end
                end
            end

            if (state == DRAIN && !bus.hold) drain_cnt <= ~drain_cnt;

            // Once frozen, the RAM keeps reading the address of the next tap, so the
            // data belonging to stage 1 is parked here on the first frozen cycle.
            if (freeze && !frozen_d) begin
                skid_a <= bus.fmap_rdata;
                skid_b <= bus.w_rdata;
            end

            if (!freeze) begin
                s1_valid <= run_go;
                s1_first <= tap_first;
                s1_last  <= tap_last;
                s1_x     <= ox;
                s1_y     <= oy;
                s2_valid <= s1_valid;
                s2_first <= s1_valid && s1_first;
                s2_last  <= s1_valid && s1_last;
                s2_x     <= s1_x;
                s2_y     <= s1_y;
                mac_a    <= frozen_d ? skid_a : bus.fmap_rdata;
                mac_b    <= frozen_d ? skid_b : bus.w_rdata;
            end
        end
    end

    assign bus.fmap_addr = fmap_addr;
    assign bus.w_addr    = w_addr;
    assign bus.mac_a     = mac_a;
    assign bus.mac_b     = mac_b;
    assign bus.mac_en    = s2_valid && !bus.hold;
    assign bus.mac_first = s2_first && !bus.hold;
    assign bus.mac_last  = s2_last && !bus.hold;
    assign bus.out_x     = s2_x;
    assign bus.out_y     = s2_y;
    assign bus.busy      = busy_state;
    assign bus.done      = (state == DONE);
endmodule
